// File: rtl/hazard_pkg.sv
// Shared types, RV32I opcode constants and operand-usage helpers for the hazard controller.
package hazard_pkg;

    localparam int OPC_W    = 7;
    localparam int LU_CNT_W = 2;

    localparam logic [OPC_W-1:0] OP_LOAD   = 7'b0000011;
    localparam logic [OPC_W-1:0] OP_STORE  = 7'b0100011;
    localparam logic [OPC_W-1:0] OP_BRANCH = 7'b1100011;
    localparam logic [OPC_W-1:0] OP_JAL    = 7'b1101111;
    localparam logic [OPC_W-1:0] OP_JALR   = 7'b1100111;
    localparam logic [OPC_W-1:0] OP_LUI    = 7'b0110111;
    localparam logic [OPC_W-1:0] OP_AUIPC  = 7'b0010111;
    localparam logic [OPC_W-1:0] OP_IMM    = 7'b0010011;

    typedef enum logic [1:0] {
        FWD_NONE = 2'b00,
        FWD_MEM  = 2'b01,
        FWD_WB   = 2'b10
    } fwd_sel_t;

    typedef enum logic [1:0] {
        HZ_RUN,
        HZ_LU_STALL,
        HZ_MEM_WAIT,
        HZ_EX_WAIT
    } hz_state_t;

    function automatic logic uses_rs1(input logic [OPC_W-1:0] op);
        return !(op == OP_LUI || op == OP_AUIPC || op == OP_JAL);
    endfunction

    function automatic logic uses_rs2(input logic [OPC_W-1:0] op);
        return uses_rs1(op) && !(op == OP_JALR || op == OP_LOAD || op == OP_IMM);
    endfunction

    function automatic logic writes_rd(input logic [OPC_W-1:0] op);
        return !(op == OP_STORE || op == OP_BRANCH);
    endfunction

endpackage

// File: rtl/hazard_fwd_sel.sv
// Forwarding select for one E-stage operand: MEM result first, then WB, x0 never forwarded.
module hazard_fwd_sel
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W = 5
) (
    input  logic [REG_ADDR_W-1:0] src,
    input  logic                  src_used,
    input  logic [REG_ADDR_W-1:0] m_rd,
    input  logic                  m_fwd_ok,
    input  logic [REG_ADDR_W-1:0] w_rd,
    input  logic                  w_we,
    output fwd_sel_t              sel
);

    always_comb begin
        sel = FWD_NONE;
        if (src_used && src != '0) begin
            if (m_fwd_ok && m_rd == src) begin
                sel = FWD_MEM;
            end else if (w_we && w_rd == src) begin
                sel = FWD_WB;
            end
        end
    end

endmodule

// File: rtl/hazard_ctrl_param.sv
// Hazard controller for the 5-stage RV32I pipeline: forwarding, load-use/mem-wait/ex-busy stalls, redirect.
// Optional stall/flush counters are built when HAZARD_PERF_CNT_EN is defined.
module hazard_ctrl_param
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W       = 5,
    parameter int OPCODE_W         = 7,
    parameter int LOAD_USE_BUBBLES = 1,
    parameter int PERF_CNT_W       = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [REG_ADDR_W-1:0] d_rs1,
    input  logic [REG_ADDR_W-1:0] d_rs2,
    input  logic [OPCODE_W-1:0]   d_opcode,
    input  logic [REG_ADDR_W-1:0] e_rs1,
    input  logic [REG_ADDR_W-1:0] e_rs2,
    input  logic [REG_ADDR_W-1:0] e_rd,
    input  logic [OPCODE_W-1:0]   e_opcode,
    input  logic [REG_ADDR_W-1:0] m_rd,
    input  logic                  m_we,
    input  logic [OPCODE_W-1:0]   m_opcode,
    input  logic [REG_ADDR_W-1:0] w_rd,
    input  logic                  w_we,
    input  logic                  dmem_ready,
    input  logic                  ex_busy,
    input  logic                  branch,
    input  logic                  branch_taken,
    input  logic                  jump,
    output fwd_sel_t              fwd_a,
    output fwd_sel_t              fwd_b,
    output logic                  pc_en,
    output logic                  f_d_en,
    output logic                  d_e_en,
    output logic                  e_m_en,
    output logic                  d_e_bubble,
    output logic                  m_w_bubble,
    output logic                  pc_src,
    output logic                  flush
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [PERF_CNT_W-1:0] stall_cycles,
    output logic [PERF_CNT_W-1:0] flush_count
`endif
);

    if (LOAD_USE_BUBBLES < 1 || LOAD_USE_BUBBLES > 3 || PERF_CNT_W < 1) begin : g_bad_param
        $error("hazard_ctrl_param: LOAD_USE_BUBBLES must be 1..3 and PERF_CNT_W >= 1");
    end

    hz_state_t           state, state_nxt;
    logic [LU_CNT_W-1:0] lu_cnt, lu_cnt_nxt;
    logic                resume_lu, resume_lu_nxt;
    logic                redir_ok;
    fwd_sel_t            fwd_a_raw, fwd_b_raw;

    logic m_fwd_ok, mem_wait_req, redirect, load_use;

    // A load result is not available in M, so only non-load writers forward from M.
    assign m_fwd_ok     = m_we && writes_rd(m_opcode) && (m_opcode != OP_LOAD);
    assign mem_wait_req = (m_opcode == OP_LOAD || m_opcode == OP_STORE) && !dmem_ready;
    assign redirect     = (branch && branch_taken) || jump;
    assign load_use     = (e_opcode == OP_LOAD) && (e_rd != '0) &&
                          ((uses_rs1(d_opcode) && d_rs1 == e_rd) ||
                           (uses_rs2(d_opcode) && d_rs2 == e_rd));

    hazard_fwd_sel #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_a (
        .src      (e_rs1),
        .src_used (uses_rs1(e_opcode)),
        .m_rd     (m_rd),
        .m_fwd_ok (m_fwd_ok),
        .w_rd     (w_rd),
        .w_we     (w_we),
        .sel      (fwd_a_raw)
    );

    hazard_fwd_sel #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_b (
        .src      (e_rs2),
        .src_used (uses_rs2(e_opcode)),
        .m_rd     (m_rd),
        .m_fwd_ok (m_fwd_ok),
        .w_rd     (w_rd),
        .w_we     (w_we),
        .sel      (fwd_b_raw)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= HZ_RUN;
            lu_cnt    <= '0;
            resume_lu <= 1'b0;
        end else begin
            state     <= state_nxt;
            lu_cnt    <= lu_cnt_nxt;
            resume_lu <= resume_lu_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        lu_cnt_nxt    = lu_cnt;
        resume_lu_nxt = resume_lu;
        redir_ok      = 1'b0;
        pc_en         = 1'b1;
        f_d_en        = 1'b1;
        d_e_en        = 1'b1;
        e_m_en        = 1'b1;
        d_e_bubble    = 1'b0;
        m_w_bubble    = 1'b0;
        unique case (state)
            HZ_RUN: begin
                if (mem_wait_req) begin
                    state_nxt     = HZ_MEM_WAIT;
                    resume_lu_nxt = 1'b0;
                end else if (ex_busy) begin
                    state_nxt = HZ_EX_WAIT;
                end else if (redirect) begin
                    redir_ok = 1'b1;
                end else if (load_use) begin
                    state_nxt  = HZ_LU_STALL;
                    lu_cnt_nxt = LU_CNT_W'(LOAD_USE_BUBBLES);
                end
            end
            HZ_LU_STALL: begin
                pc_en      = 1'b0;
                f_d_en     = 1'b0;
                d_e_bubble = 1'b1;
                if (mem_wait_req) begin
                    // This cycle's bubble still counts; resume with what remains.
                    state_nxt     = HZ_MEM_WAIT;
                    resume_lu_nxt = (lu_cnt != LU_CNT_W'(1));
                    lu_cnt_nxt    = lu_cnt - LU_CNT_W'(1);
                end else if (redirect) begin
                    redir_ok   = 1'b1;
                    pc_en      = 1'b1;
                    f_d_en     = 1'b1;
                    d_e_bubble = 1'b0;
                    state_nxt  = HZ_RUN;
                end else if (lu_cnt == LU_CNT_W'(1)) begin
                    state_nxt = HZ_RUN;
                end else begin
                    lu_cnt_nxt = lu_cnt - LU_CNT_W'(1);
                end
            end
            HZ_MEM_WAIT: begin
                pc_en      = 1'b0;
                f_d_en     = 1'b0;
                d_e_en     = 1'b0;
                e_m_en     = 1'b0;
                m_w_bubble = 1'b1;
                if (dmem_ready) begin
                    state_nxt = resume_lu ? HZ_LU_STALL : HZ_RUN;
                end
            end
            HZ_EX_WAIT: begin
                // E holds its instruction; the gated E output feeds a NOP into M.
                pc_en  = 1'b0;
                f_d_en = 1'b0;
                d_e_en = 1'b0;
                if (mem_wait_req) begin
                    state_nxt     = HZ_MEM_WAIT;
                    resume_lu_nxt = 1'b0;
                end else if (!ex_busy) begin
                    state_nxt = HZ_RUN;
                end
            end
            default: state_nxt = HZ_RUN;
        endcase
        if (!rst_n) begin
            redir_ok   = 1'b0;
            pc_en      = 1'b1;
            f_d_en     = 1'b1;
            d_e_en     = 1'b1;
            e_m_en     = 1'b1;
            d_e_bubble = 1'b0;
            m_w_bubble = 1'b0;
        end
    end

    assign pc_src = redir_ok;
    assign flush  = redir_ok;
    assign fwd_a  = rst_n ? fwd_a_raw : FWD_NONE;
    assign fwd_b  = rst_n ? fwd_b_raw : FWD_NONE;

`ifdef HAZARD_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if (!pc_en && stall_cycles != '1) begin
                stall_cycles <= stall_cycles + PERF_CNT_W'(1);
            end
            if (flush && flush_count != '1) begin
                flush_count <= flush_count + PERF_CNT_W'(1);
            end
        end
    end
`endif

endmodule
